// File: rtl/sd_pkg.sv
// Shared constants and types for the SD-card SPI master.
package sd_pkg;
    localparam int unsigned SD_CLK_DIV   = 4;
    localparam int unsigned SD_BYTE_BITS = 8;
    localparam logic        SD_IDLE_MOSI = 1'b1;

    typedef logic [SD_BYTE_BITS-1:0] sd_byte_t;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } sd_phase_e;
endpackage

// File: rtl/sd_spi_clkgen.sv
// Free-running byte-slot timer: divider, SCLK phase, bit counter and host strobe.
module sd_spi_clkgen
    import sd_pkg::*;
#(
    parameter int unsigned CLK_DIV = SD_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rise_o,
    output logic fall_o,
    output logic boundary_o,
    output logic phase_high_o,
    output logic dclk_o
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(SD_BYTE_BITS);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SD_BYTE_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(SD_BYTE_BITS / 2);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    sd_phase_e        half_q, half_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             dclk_q, dclk_d;
    logic             tick;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            half_q    <= PH_LOW;
            bit_cnt_q <= '0;
            dclk_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            half_q    <= half_d;
            bit_cnt_q <= bit_cnt_d;
            dclk_q    <= dclk_d;
        end
    end

    always_comb begin
        tick      = (div_cnt_q == DIV_MAX);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        half_d    = half_q;
        bit_cnt_d = bit_cnt_q;
        if (tick) begin
            half_d = (half_q == PH_LOW) ? PH_HIGH : PH_LOW;
            if (half_q == PH_HIGH) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
        // Strobe is derived from the next count so it lines up with bit_cnt_q.
        dclk_d = (bit_cnt_d < BIT_HALF);
    end

    assign rise_o       = tick && (half_q == PH_LOW);
    assign fall_o       = tick && (half_q == PH_HIGH);
    assign boundary_o   = fall_o && (bit_cnt_q == BIT_LAST);
    assign phase_high_o = (half_q == PH_HIGH);
    assign dclk_o       = dclk_q;
endmodule

// File: rtl/sd_spi_master.sv
// Byte-oriented mode-0 SPI master for the SD-card peripheral.
module sd_spi_master
    import sd_pkg::*;
#(
    parameter int unsigned CLK_DIV = SD_CLK_DIV
) (
    input  logic       MasterCLK,
    input  logic       Reset,
    input  logic       SPI_MISO,
    output logic       SPI_MOSI,
    output logic       SPI_SCLK,
    output logic       SPI_CS,
    output logic       DataClockRegister,
    input  logic [7:0] OuputDataRegister,
    input  logic       SPI_EnableRegister,
    input  logic       SPI_EnableCSRegister,
    output logic [7:0] InputDataRegister,
    output logic       RxValid
);
    logic     rise, fall, boundary, phase_high;
    logic     active_q, active_d;
    sd_byte_t shreg_q, shreg_d;
    logic     miso_s_q, miso_s_d;
    sd_byte_t rx_q, rx_d;
    logic     rxv_q, rxv_d;
    logic     cs_q, cs_d;

    sd_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_i        (MasterCLK),
        .rst_i        (Reset),
        .rise_o       (rise),
        .fall_o       (fall),
        .boundary_o   (boundary),
        .phase_high_o (phase_high),
        .dclk_o       (DataClockRegister)
    );

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            active_q <= 1'b0;
            shreg_q  <= '1;
            miso_s_q <= 1'b0;
            rx_q     <= '0;
            rxv_q    <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            shreg_q  <= shreg_d;
            miso_s_q <= miso_s_d;
            rx_q     <= rx_d;
            rxv_q    <= rxv_d;
            cs_q     <= cs_d;
        end
    end

    always_comb begin
        active_d = active_q;
        shreg_d  = shreg_q;
        miso_s_d = miso_s_q;
        rx_d     = rx_q;
        rxv_d    = 1'b0;
        cs_d     = ~SPI_EnableCSRegister;
        if (rise) begin
            miso_s_d = SPI_MISO;
        end
        // The last received bit never enters shreg: it goes straight into rx.
        if (boundary) begin
            active_d = SPI_EnableRegister;
            if (SPI_EnableRegister) begin
                shreg_d = OuputDataRegister;
            end
            if (active_q) begin
                rx_d  = {shreg_q[SD_BYTE_BITS-2:0], miso_s_q};
                rxv_d = 1'b1;
            end
        end else if (fall) begin
            shreg_d = {shreg_q[SD_BYTE_BITS-2:0], miso_s_q};
        end
    end

    assign SPI_SCLK          = active_q & phase_high;
    assign SPI_MOSI          = active_q ? shreg_q[SD_BYTE_BITS-1] : SD_IDLE_MOSI;
    assign SPI_CS            = cs_q;
    assign InputDataRegister = rx_q;
    assign RxValid           = rxv_q;
endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master with CLK_DIV = 4 (64-cycle byte slots).
module tb_sd_spi_master;
    logic       clk;
    logic       rst;
    logic       miso;
    logic       mosi;
    logic       sclk;
    logic       cs;
    logic       dclk;
    logic [7:0] tx_data;
    logic       en;
    logic       en_cs;
    logic [7:0] rx_data;
    logic       rxv;

    int unsigned n_asserts = 0;
    int unsigned n_fail    = 0;
    int          n;

    sd_spi_master #(
        .CLK_DIV (4)
    ) dut (
        .MasterCLK            (clk),
        .Reset                (rst),
        .SPI_MISO             (miso),
        .SPI_MOSI             (mosi),
        .SPI_SCLK             (sclk),
        .SPI_CS               (cs),
        .DataClockRegister    (dclk),
        .OuputDataRegister    (tx_data),
        .SPI_EnableRegister   (en),
        .SPI_EnableCSRegister (en_cs),
        .InputDataRegister    (rx_data),
        .RxValid              (rxv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    initial begin
        logic       sclk_seen;
        logic       mosi_low_seen;
        logic       rxv_seen;
        logic       prev_dclk;
        logic [7:0] a5;
        logic [7:0] rx_byte;
        int         hi_cnt;
        int         gap_err;
        int         ph;
        int         b;

        rst = 1'b1; miso = 1'b0; tx_data = 8'h00; en = 1'b0; en_cs = 1'b0;
        n = 0;
        a5 = 8'hA5;
        sclk_seen = 1'b0; mosi_low_seen = 1'b0; rxv_seen = 1'b0;
        prev_dclk = 1'b1; rx_byte = 8'h00; hi_cnt = 0; gap_err = 0;

        repeat (3) tick();
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b1);
        chk("rst_cs",   cs,   1'b1);
        chk("rst_dclk", dclk, 1'b1);
        chk("rst_rxd",  rx_data, 8'h00);
        chk("rst_rxv",  rxv,  1'b0);

        rst = 1'b0;
        n = 0;
        while (n < 512) begin
            tick();
            if (n < 128) begin
                sclk_seen     = sclk_seen | sclk;
                mosi_low_seen = mosi_low_seen | ~mosi;
            end
            if (n == 127) begin
                chk("idle_sclk_never_high", sclk_seen, 1'b0);
                chk("idle_mosi_never_low",  mosi_low_seen, 1'b0);
            end
            if (n == 31)  chk("dclk_31",  dclk, 1'b1);
            if (n == 32)  chk("dclk_32",  dclk, 1'b0);
            if (n == 63)  chk("dclk_63",  dclk, 1'b0);
            if (n == 64)  chk("dclk_64",  dclk, 1'b1);
            if (n == 96)  chk("dclk_96",  dclk, 1'b0);
            if (n == 128) chk("dclk_128", dclk, 1'b1);
            if (n == 100) begin
                tx_data = 8'hA5; en = 1'b1; miso = 1'b1;
            end
            if (n >= 128 && n < 192) begin
                ph = (n - 128) % 8;
                b  = (n - 128) / 8;
                if (sclk === 1'b1) hi_cnt++;
                if (ph == 4) begin
                    chk("a5_sclk_high", sclk, 1'b1);
                    chk("a5_mosi_bit",  mosi, a5[7-b]);
                end
                if (ph == 0) chk("a5_sclk_low", sclk, 1'b0);
            end
            if (n == 191) begin
                chk("a5_sclk_high_cycles", hi_cnt, 32);
                chk("rxv_before_boundary", rxv, 1'b0);
            end
            if (n == 160) tx_data = 8'h3C;
            if (n == 192) begin
                chk("rx_ff_valid", rxv, 1'b1);
                chk("rx_ff_data",  rx_data, 8'hFF);
                miso = 1'b0;
            end
            if (n == 193) begin
                chk("rx_ff_pulse_end", rxv, 1'b0);
                chk("rx_ff_hold",      rx_data, 8'hFF);
            end
            if (n == 256) begin
                chk("rx_00_valid", rxv, 1'b1);
                chk("rx_00_data",  rx_data, 8'h00);
                tx_data = 8'h00;
                miso = 1'b1;
            end
            if (n >= 257 && prev_dclk === 1'b1 && dclk === 1'b0) tx_data = tx_data + 8'h01;
            if (n >= 320) begin
                if (sclk !== 1'(((n - 320) / 4) % 2)) gap_err++;
                if ((n - 320) % 8 == 4) rx_byte = {rx_byte[6:0], mosi};
                if ((n - 320) % 64 == 63) chk("incr_byte", rx_byte, 8'((n - 320) / 64 + 1));
            end
            if (n == 511) chk("incr_sclk_continuous", gap_err, 0);
            prev_dclk = dclk;
        end

        chk("cs_before", cs, 1'b1);
        en_cs = 1'b1;
        chk("cs_same_cycle", cs, 1'b1);
        tick();
        chk("cs_asserted", cs, 1'b0);
        en_cs = 1'b0;
        tick();
        chk("cs_released", cs, 1'b1);

        while (n < 540) tick();
        chk("pre_rst_sclk", sclk, 1'b1);
        chk("pre_rst_mosi", mosi, 1'b0);
        chk("pre_rst_rxd",  rx_data, 8'hFF);
        rst = 1'b1;
        tick();
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_mosi", mosi, 1'b1);
        chk("abort_rxv",  rxv,  1'b0);
        chk("abort_rxd",  rx_data, 8'h00);
        chk("abort_dclk", dclk, 1'b1);
        rst = 1'b0;
        n = 0;
        sclk_seen = 1'b0;
        rxv_seen  = 1'b0;
        while (n < 64) begin
            tick();
            sclk_seen = sclk_seen | sclk;
            rxv_seen  = rxv_seen | rxv;
        end
        chk("post_rst_slot_idle", sclk_seen, 1'b0);
        chk("post_rst_no_rxv",    rxv_seen, 1'b0);
        while (n < 68) tick();
        chk("post_rst_first_xfer_sclk", sclk, 1'b1);
        chk("post_rst_first_xfer_mosi", mosi, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_spi_master.md
# sd_spi_master

Byte-oriented SPI master (mode 0) for the SD-card peripheral, sitting between the SoC register file and the card pins. Runs a free-running byte-slot timer, emits a byte-rate strobe (`DataClockRegister`) telling the host when to present the next byte, and, when enabled, shifts that byte out MSB-first on MOSI while capturing a byte from MISO. Chip select is a direct, registered function of a host register bit.

## Interface
- `CLK_DIV`, default 4, `MasterCLK` cycles per SCLK half-period; must be ≥ 1.
- `MasterCLK`  in  1  system clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `SPI_MISO`  in  1  serial data from card.
- `SPI_MOSI`  out  1  serial data to card; idles high.
- `SPI_SCLK`  out  1  SPI clock; idles low (CPOL=0).
- `SPI_CS`  out  1  chip select, active low.
- `DataClockRegister`  out  1  byte-slot strobe; its falling edge tells the host to update `OuputDataRegister` and `SPI_EnableRegister`.
- `OuputDataRegister`  in  8  next byte to transmit; the port name is spelled exactly this way.
- `SPI_EnableRegister`  in  1  1 = transfer in the next byte slot; 0 = idle slot.
- `SPI_EnableCSRegister`  in  1  1 = assert CS (drive `SPI_CS` low).
- `InputDataRegister`  out  8  last byte received.
- `RxValid`  out  1  one-cycle pulse when `InputDataRegister` is updated.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 and free-runs. A tick occurs when `div_cnt == CLK_DIV-1`.
- Phase bit `half` toggles on each tick: 0 = SCLK-low phase, 1 = SCLK-high phase.
- Bit counter `bit_cnt` (0..7) increments on each tick that ends a high phase. Therefore one bit slot = 2·CLK_DIV cycles and one byte slot = 16·CLK_DIV cycles.
- Byte boundary: a tick with `half = 1` and `bit_cnt = 7`. At this edge:
  - `active <= SPI_EnableRegister`.
  - If enabled, `shreg <= OuputDataRegister`.
  - If `active` was 1 for the ending slot, `InputDataRegister <=` the completed received byte and `RxValid` pulses for 1 cycle.
- End of a low phase (SCLK rising edge): sample `SPI_MISO` into `miso_s`.
- End of a high phase (SCLK falling edge), other than at a byte boundary: `shreg <= {shreg[6:0], miso_s}`.
- Outputs:
  - `SPI_SCLK = active & half`.
  - `SPI_MOSI = active ? shreg[7] : 1`.
- `DataClockRegister` is registered and equals 1 while `bit_cnt` is 0..3 and 0 while it is 4..7. It runs continuously, even when `active = 0`, so the host can start the first transfer.
- `SPI_CS` is registered as `~SPI_EnableCSRegister`. It is independent of the slot timing.
- Changes to `SPI_EnableRegister` or `OuputDataRegister` mid-slot have no effect until the next boundary.

## Timing
- Reset values: `div_cnt = 0`, `half = 0`, `bit_cnt = 0`, `active = 0`, `shreg = 0xFF`, `SPI_SCLK = 0`, `SPI_MOSI = 1`, `SPI_CS = 1`, `DataClockRegister = 1`, `InputDataRegister = 0x00`, `RxValid = 0`.
- The first slot after reset is always idle. The earliest transfer starts at the first boundary, 16·CLK_DIV cycles after reset deassertion.
- `DataClockRegister` falls 8·CLK_DIV cycles into each slot. The host has 8·CLK_DIV cycles to settle data before the boundary.
- Data latency: a byte valid at boundary k is on MOSI for the whole of slot k+1. It is received into `InputDataRegister` at boundary k+1 (`RxValid` high in the following cycle).
- Back-to-back enabled slots give a continuous SCLK with no gap between bytes.
- Reset asserted mid-byte aborts immediately: SCLK low, MOSI high, partial byte discarded, no `RxValid`.
- `SPI_CS` follows `SPI_EnableCSRegister` with 1-cycle latency, including mid-byte. Framing bytes with CS is the host's responsibility.

## Structure
- Shared package `sd_pkg`: default `CLK_DIV`, `SD_BYTE_BITS = 8`, and `SD_IDLE_MOSI = 1`.
- One natural sub-module: `sd_spi_clkgen`, containing the divider, the phase bit, `bit_cnt`, and the tick, boundary, and strobe outputs.
- The shift and receive datapath stay in the top module.

## Test plan
All scenarios use CLK_DIV = 4, so one byte slot is 64 cycles.
- Reset then idle (`SPI_EnableRegister = 0`): `SPI_SCLK` stays 0 and `SPI_MOSI` stays 1. `DataClockRegister` toggles with period 64 cycles and a 50% duty cycle.
- `OuputDataRegister = 0xA5` with enable set before a boundary: MOSI carries 1,0,1,0,0,1,0,1 across 8 SCLK pulses, each SCLK high for 4 cycles.
- `SPI_MISO` held 1 during an enabled slot: `InputDataRegister = 0xFF` and `RxValid` is a single-cycle pulse. Tying MISO to 0 gives 0x00.
- Host increments the data on every `DataClockRegister` falling edge, starting from 0x00 with enable set: consecutive slots transmit 0x01, 0x02, … with continuous SCLK.
- `SPI_EnableCSRegister` 0→1→0: `SPI_CS` goes 1→0→1, each change one cycle after the input.
- Reset asserted during bit 3 of a transfer: the next cycle shows SCLK = 0, MOSI = 1 and no `RxValid`, and the next slot is idle.
